// File: rtl/vga_board_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_board_engine                                                           |
// | Two-stage pipelined VGA scan engine drawing NUM_BOARDS square game boards  |
// | with grid lines and a blinking cursor.                                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vga_board_engine #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int BOARD_N      = 5,
    parameter int CELL_PX      = 40,
    parameter int NUM_BOARDS   = 2,
    parameter int X0           = 40,
    parameter int Y0           = 140,
    parameter int GAP          = 40,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_BOARDS*BOARD_N*BOARD_N*2-1:0] boards,
    input  logic [1:0]                            cur_board,
    input  logic [2:0]                            cur_i,
    input  logic [2:0]                            cur_j,
    output logic                                  hsync,
    output logic                                  vsync,
    output logic                                  sync_b,
    output logic                                  blank_b,
    output logic [7:0]                            r,
    output logic [7:0]                            g,
    output logic [7:0]                            b,
    output logic                                  frame_start
);
    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = $clog2(c_H_TOTAL);
    localparam int c_VW      = $clog2(c_V_TOTAL);
    localparam int c_PW      = $clog2(CELL_PX);
    localparam int c_GW      = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int c_FW      = $clog2(BLINK_FRAMES + 1);
    localparam int c_CELLS   = NUM_BOARDS * BOARD_N * BOARD_N;
    localparam int c_CW      = (c_CELLS > 1) ? $clog2(c_CELLS) : 1;

    localparam logic [c_HW-1:0] c_H_LAST  = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_LAST  = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_HW-1:0] c_HA      = c_HW'(H_ACTIVE);
    localparam logic [c_VW-1:0] c_VA      = c_VW'(V_ACTIVE);
    localparam logic [c_HW:0]   c_HS_ON   = (c_HW+1)'(H_ACTIVE + H_FP);
    localparam logic [c_HW:0]   c_HS_OFF  = (c_HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_VW:0]   c_VS_ON   = (c_VW+1)'(V_ACTIVE + V_FP);
    localparam logic [c_VW:0]   c_VS_OFF  = (c_VW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_HW-1:0] c_X0      = c_HW'(X0);
    localparam logic [c_VW-1:0] c_Y0      = c_VW'(Y0);
    localparam logic [c_PW-1:0] c_PX_LAST = c_PW'(CELL_PX - 1);
    localparam logic [c_PW-1:0] c_PX_M2   = c_PW'(CELL_PX - 2);
    localparam logic [2:0]      c_N_LAST  = 3'(BOARD_N - 1);
    localparam logic [1:0]      c_B_LAST  = 2'(NUM_BOARDS - 1);
    localparam logic [c_GW-1:0] c_G_LAST  = c_GW'(GAP - 1);
    localparam logic [c_FW-1:0] c_F_LAST  = c_FW'(BLINK_FRAMES - 1);

    // stage 0: raster counters and incremental region trackers
    logic [c_HW-1:0] r_hcnt, w_hcnt_nx;
    logic [c_VW-1:0] r_vcnt, w_vcnt_nx;
    logic            w_h_wrap, w_v_wrap;
    logic            r_hin, w_hin_nx, r_hgap, w_hgap_nx;
    logic [1:0]      r_hb, w_hb_nx;
    logic [c_PW-1:0] r_hpx, w_hpx_nx, r_vpx, w_vpx_nx;
    logic [2:0]      r_hcol, w_hcol_nx, r_vrow, w_vrow_nx;
    logic [c_GW-1:0] r_gcnt, w_gcnt_nx;
    logic            r_vin, w_vin_nx;

    always_comb begin
        w_h_wrap  = (r_hcnt == c_H_LAST);
        w_v_wrap  = (r_vcnt == c_V_LAST);
        w_hcnt_nx = w_h_wrap ? '0 : r_hcnt + 1'b1;
        w_vcnt_nx = r_vcnt;
        if (w_h_wrap) begin
            w_vcnt_nx = w_v_wrap ? '0 : r_vcnt + 1'b1;
        end

        w_hin_nx  = r_hin;
        w_hgap_nx = r_hgap;
        w_hb_nx   = r_hb;
        w_hpx_nx  = r_hpx;
        w_hcol_nx = r_hcol;
        w_gcnt_nx = r_gcnt;
        if (w_hcnt_nx == c_X0) begin
            w_hin_nx  = 1'b1;
            w_hgap_nx = 1'b0;
            w_hb_nx   = '0;
            w_hpx_nx  = '0;
            w_hcol_nx = '0;
            w_gcnt_nx = '0;
        end else if (w_h_wrap) begin
            w_hin_nx  = 1'b0;
            w_hgap_nx = 1'b0;
        end else if (r_hin) begin
            if (r_hpx == c_PX_LAST) begin
                w_hpx_nx = '0;
                if (r_hcol == c_N_LAST) begin
                    w_hcol_nx = '0;
                    w_hin_nx  = 1'b0;
                    if (r_hb != c_B_LAST) begin
                        if (GAP == 0) begin
                            w_hin_nx = 1'b1;
                            w_hb_nx  = r_hb + 1'b1;
                        end else begin
                            w_hgap_nx = 1'b1;
                            w_gcnt_nx = '0;
                        end
                    end
                end else begin
                    w_hcol_nx = r_hcol + 1'b1;
                end
            end else begin
                w_hpx_nx = r_hpx + 1'b1;
            end
        end else if (r_hgap) begin
            if (r_gcnt == c_G_LAST) begin
                w_hgap_nx = 1'b0;
                w_hin_nx  = 1'b1;
                w_hb_nx   = r_hb + 1'b1;
            end else begin
                w_gcnt_nx = r_gcnt + 1'b1;
            end
        end

        w_vin_nx  = r_vin;
        w_vpx_nx  = r_vpx;
        w_vrow_nx = r_vrow;
        if (w_h_wrap) begin
            if (w_vcnt_nx == c_Y0) begin
                w_vin_nx  = 1'b1;
                w_vpx_nx  = '0;
                w_vrow_nx = '0;
            end else if (w_v_wrap) begin
                w_vin_nx = 1'b0;
            end else if (r_vin) begin
                if (r_vpx == c_PX_LAST) begin
                    w_vpx_nx = '0;
                    if (r_vrow == c_N_LAST) begin
                        w_vrow_nx = '0;
                        w_vin_nx  = 1'b0;
                    end else begin
                        w_vrow_nx = r_vrow + 1'b1;
                    end
                end else begin
                    w_vpx_nx = r_vpx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
            r_hin  <= (X0 == 0);
            r_hgap <= 1'b0;
            r_hb   <= '0;
            r_hpx  <= '0;
            r_hcol <= '0;
            r_gcnt <= '0;
            r_vin  <= (Y0 == 0);
            r_vpx  <= '0;
            r_vrow <= '0;
        end else begin
            r_hcnt <= w_hcnt_nx;
            r_vcnt <= w_vcnt_nx;
            r_hin  <= w_hin_nx;
            r_hgap <= w_hgap_nx;
            r_hb   <= w_hb_nx;
            r_hpx  <= w_hpx_nx;
            r_hcol <= w_hcol_nx;
            r_gcnt <= w_gcnt_nx;
            r_vin  <= w_vin_nx;
            r_vpx  <= w_vpx_nx;
            r_vrow <= w_vrow_nx;
        end
    end

    logic w_org, w_act, w_hs, w_vs;
    assign w_org = (r_hcnt == '0) && (r_vcnt == '0);
    assign w_act = (r_hcnt < c_HA) && (r_vcnt < c_VA);
    assign w_hs  = !(({1'b0, r_hcnt} >= c_HS_ON) && ({1'b0, r_hcnt} < c_HS_OFF));
    assign w_vs  = !(({1'b0, r_vcnt} >= c_VS_ON) && ({1'b0, r_vcnt} < c_VS_OFF));

    // The shadow takes the blink phase from before this frame's update, so
    // the first BLINK_FRAMES frames after reset show the cursor.
    logic            r_blink, r_cur_blink, r_cur_en;
    logic [c_FW-1:0] r_fcnt;
    logic [1:0]      r_cur_b;
    logic [2:0]      r_cur_i, r_cur_j;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fcnt      <= '0;
            r_blink     <= 1'b1;
            r_cur_blink <= 1'b1;
            r_cur_en    <= 1'b0;
            r_cur_b     <= '0;
            r_cur_i     <= '0;
            r_cur_j     <= '0;
        end else if (w_org) begin
            r_cur_blink <= r_blink;
            r_cur_en    <= ({1'b0, cur_board} < 3'(NUM_BOARDS)) &&
                           ({1'b0, cur_i} < 4'(BOARD_N)) &&
                           ({1'b0, cur_j} < 4'(BOARD_N));
            r_cur_b     <= cur_board;
            r_cur_i     <= cur_i;
            r_cur_j     <= cur_j;
            if (r_fcnt == c_F_LAST) begin
                r_fcnt  <= '0;
                r_blink <= ~r_blink;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    logic [1:0]      w_cell [c_CELLS];
    logic [c_CW-1:0] w_flat;

    for (genvar k = 0; k < c_CELLS; k++) begin : g_cells
        assign w_cell[k] = boards[2*k +: 2];
    end

    assign w_flat = c_CW'(r_hb) * c_CW'(BOARD_N * BOARD_N) +
                    c_CW'(r_vrow) * c_CW'(BOARD_N) + c_CW'(r_hcol);

    // stage 1
    logic            r1_act, r1_hs, r1_vs, r1_org, r1_inb;
    logic [1:0]      r1_b, r1_code;
    logic [2:0]      r1_row, r1_col;
    logic [c_PW-1:0] r1_px, r1_py;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_act  <= 1'b0;
            r1_hs   <= 1'b1;
            r1_vs   <= 1'b1;
            r1_org  <= 1'b0;
            r1_inb  <= 1'b0;
            r1_b    <= '0;
            r1_code <= '0;
            r1_row  <= '0;
            r1_col  <= '0;
            r1_px   <= '0;
            r1_py   <= '0;
        end else begin
            r1_act  <= w_act;
            r1_hs   <= w_hs;
            r1_vs   <= w_vs;
            r1_org  <= w_org;
            r1_inb  <= r_hin && r_vin;
            r1_b    <= r_hb;
            r1_code <= w_cell[w_flat];
            r1_row  <= r_vrow;
            r1_col  <= r_hcol;
            r1_px   <= r_hpx;
            r1_py   <= r_vpx;
        end
    end

    logic        w_border, w_cursor;
    logic [23:0] w_rgb;

    always_comb begin
        w_border = (r1_px <= c_PW'(1)) || (r1_px >= c_PX_M2) ||
                   (r1_py <= c_PW'(1)) || (r1_py >= c_PX_M2);
        w_cursor = r_cur_en && r_cur_blink && (r1_b == r_cur_b) &&
                   (r1_row == r_cur_i) && (r1_col == r_cur_j);
        w_rgb    = 24'h000000;
        if (!r1_act) begin
            w_rgb = 24'h000000;
        end else if (!r1_inb) begin
            w_rgb = 24'h141428;
        end else if (w_border && w_cursor) begin
            w_rgb = 24'hFFFF00;
        end else if ((r1_px == '0) || (r1_py == '0)) begin
            w_rgb = 24'h000000;
        end else begin
            case (r1_code)
                2'b00:   w_rgb = 24'h0000C8;
                2'b01:   w_rgb = 24'h808080;
                2'b10:   w_rgb = 24'hFF0000;
                default: w_rgb = 24'hFFFFFF;
            endcase
        end
    end

    // stage 2: registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            sync_b      <= 1'b1;
            blank_b     <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= r1_hs;
            vsync       <= r1_vs;
            sync_b      <= r1_hs & r1_vs;
            blank_b     <= r1_act;
            r           <= w_rgb[23:16];
            g           <= w_rgb[15:8];
            b           <= w_rgb[7:0];
            frame_start <= r1_org;
        end
    end
endmodule
`default_nettype wire

// File: doc/vga_board_engine.md
# vga_board_engine

Parametrised VGA scan engine for the game display: generates sync/blank timing from configurable porch and sync parameters, walks up to NUM_BOARDS square game boards of BOARD_N×BOARD_N cells, and produces registered RGB with grid lines and a blinking cursor. It runs entirely on the pixel clock after the PLL, replacing the fixed 640×480, two-board timing-plus-video path with one pipelined, resolution- and board-agnostic block.

## Interface

- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync width, back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (lines)
- BOARD_N, 5, cells per board side (1..8)
- CELL_PX, 40, cell size in pixels (≥2)
- NUM_BOARDS, 2, boards drawn left to right (1..4)
- X0 / Y0 / GAP, 40 / 140 / 40, top-left of board 0 and horizontal gap between boards
- BLINK_FRAMES, 30, frames per cursor blink half-period (≥1)

- clk  in  1  pixel clock (vgaclk domain)
- rst  in  1  asynchronous, active-high reset
- boards  in  NUM_BOARDS*BOARD_N*BOARD_N*2  cell codes; board b, row i, col j at bits [2*((b*BOARD_N+i)*BOARD_N+j) +: 2]
- cur_board  in  2  board showing the cursor
- cur_i / cur_j  in  3 / 3  cursor row / column
- hsync / vsync  out  1  active-low syncs
- sync_b  out  1  hsync & vsync
- blank_b  out  1  high during active video
- r / g / b  out  8 each  pixel colour
- frame_start  out  1  one-cycle pulse coincident with output pixel (0,0)

## Operation

- Reset (async): hcnt=vcnt=0, blink phase=1, all pipeline stages cleared; outputs hsync=vsync=sync_b=1, blank_b=0, r=g=b=0, frame_start=0. Reset mid-frame restarts at (0,0) on the first edge after release.
- Stage 0: hcnt 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP), wraps to 0 and advances vcnt; vcnt wraps at V_TOTAL. Active when hcnt<H_ACTIVE and vcnt<V_ACTIVE. hsync low for H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC; vsync likewise.
- Cell tracking is incremental, no dividers: per line, horizontal region counter (board index, in-cell pixel 0..CELL_PX-1, column 0..BOARD_N-1, gap counter) restarts at hcnt=X0; vertical counterpart (in-cell line, row) restarts at vcnt=Y0 and advances once per line at hcnt wrap. Pixel is "in board b" when inside [X0+b*(BOARD_N*CELL_PX+GAP), +BOARD_N*CELL_PX) horizontally and [Y0, Y0+BOARD_N*CELL_PX) vertically.
- Stage 1 registers board, row, col, in-cell offsets, in-board flag, active, syncs; stage 2 registers colour and delayed syncs.
- Colour priority: not active → 0/0/0; outside all boards → background 20/20/40; cursor border (in-cell offset x or y ∈ {0,1,CELL_PX-2,CELL_PX-1}, cell matches cursor, blink phase=1) → 255/255/0; grid line (offset x=0 or y=0) → 0/0/0; else by code: 00 water 0/0/200, 01 ship 128/128/128, 10 hit 255/0/0, 11 miss 255/255/255.
- Cursor inputs captured into shadow registers at stage-0 (0,0); stable for the whole frame. cur_board ≥ NUM_BOARDS, or cur_i/cur_j ≥ BOARD_N → no cursor drawn that frame.
- Blink: frame counter increments at each stage-0 (0,0); on reaching BLINK_FRAMES it clears and blink phase toggles.
- Boards overrunning H_ACTIVE/V_ACTIVE are clipped by the active test; no wrap.

## Timing

- Latency: exactly 2 cycles from stage-0 counter to all outputs; hsync, vsync, sync_b, blank_b, rgb, frame_start mutually aligned.
- All outputs registered; no combinational input→output path.
- boards may change any cycle; used value is the one sampled at stage 1 of that pixel.
- Line period H_TOTAL cycles, frame period H_TOTAL*V_TOTAL cycles (800×525 default).

## Test plan

- Reset release: frame_start first high on cycle 2; hsync falls at output cycle 656+2 and rises at 752+2 of line 0; blank_b low at output hcnt 640..799.
- Frame period: count clocks between frame_start pulses = 420000; vsync low exactly 2 lines (lines 490–491).
- All-water boards, cursor off (cur_i=7): pixel (X0+1,Y0+1)=0/0/200; (X0,Y0+5)=0/0/0 grid; (0,0)=20/20/40; (X0+200+1,Y0+1) is gap → 20/20/40.
- Board 1 cell (2,3)=10, others 00: pixel (40+240+3*40+5, 140+2*40+5)=255/0/0; neighbouring cell water.
- Cursor board 0 (1,1), BLINK_FRAMES=2: border pixel (40+40+1,140+40+20) yellow in frames 0–1, cell colour in frames 2–3, yellow again frame 4; cursor change mid-frame takes effect next frame only.
- Assert rst mid-line 100: outputs go to reset values immediately; after release counters restart at (0,0) and frame_start fires 2 cycles later.
